// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - collects Op/A/B beats from a 4-bit bus and holds them for the ALU preprocessor (option: ALU_LOADER_SKIP_EN)
module alu_operand_loader (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [2:0] Op,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] op_count
);

    localparam logic [1:0] LOAD_OP = 2'd0;
    localparam logic [1:0] LOAD_A  = 2'd1;
    localparam logic [1:0] LOAD_B  = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;

    logic [1:0] state;
    logic       accept;
    logic       consume;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= LOAD_OP;
            A        <= 4'd0;
            B        <= 4'd0;
            Op       <= 3'd0;
            op_count <= 8'd0;
        end else begin
            case (state)
                LOAD_OP: if (accept) begin
                    Op <= in_data[2:0];
`ifdef ALU_LOADER_SKIP_EN
                    // B-only opcode: A is unused downstream, so zero it and skip its beat
                    if (in_data[2:0] == 3'b011) begin
                        A     <= 4'd0;
                        state <= LOAD_B;
                    end else begin
                        state <= LOAD_A;
                    end
`else
                    state <= LOAD_A;
`endif
                end
                LOAD_A: if (accept) begin
                    A <= in_data;
`ifdef ALU_LOADER_SKIP_EN
                    if (Op == 3'b001 || Op == 3'b010) begin
                        B     <= 4'd0;
                        state <= HOLD;
                    end else begin
                        state <= LOAD_B;
                    end
`else
                    state <= LOAD_B;
`endif
                end
                LOAD_B: if (accept) begin
                    B     <= in_data;
                    state <= HOLD;
                end
                default: if (consume) begin
                    op_count <= op_count + 8'd1;
                    state    <= LOAD_OP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - directed self-checking bench for alu_operand_loader (follows ALU_LOADER_SKIP_EN)
module tb_alu_operand_loader;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] Op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] op_count;

    int tests  = 0;
    int failed = 0;

    alu_operand_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Op        (Op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1 with in_valid dropped.
    task automatic send_beat(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        int last;
        int pulses;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b0;
        #1;
        check("rst_A", A, 0);
        check("rst_B", B, 0);
        check("rst_Op", Op, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_op_count", op_count, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", in_ready, 1);

        // Reset in the middle of LOAD_B
        send_beat(4'h0);
        send_beat(4'h5);
        check("mid_A_loaded", A, 5);
        check("mid_in_ready", in_ready, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_A", A, 0);
        check("midrst_B", B, 0);
        check("midrst_Op", Op, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_op_count", op_count, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid2", out_valid, 0);

        // Basic load, held while out_ready is low, stray beats ignored
        send_beat(4'h0);
        check("basic_ov_after1", out_valid, 0);
        send_beat(4'h3);
        check("basic_ov_after2", out_valid, 0);
        send_beat(4'h9);
        check("basic_ov", out_valid, 1);
        check("basic_Op", Op, 0);
        check("basic_A", A, 3);
        check("basic_B", B, 9);
        in_valid = 1'b1;
        in_data  = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_ov", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_A", A, 3);
            check("hold_B", B, 9);
            check("hold_Op", Op, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("basic_count", op_count, 1);
        check("basic_ov_drop", out_valid, 0);
        check("basic_back_ready", in_ready, 1);

        // Gapped handshake: one idle cycle after every beat
        send_beat(4'hD);
        @(posedge clk);
        #1;
        check("gap_Op", Op, 5);
        check("gap_A_prev", A, 3);
        send_beat(4'h6);
        @(posedge clk);
        #1;
        check("gap_A", A, 6);
        check("gap_B_prev", B, 9);
        check("gap_ov_mid", out_valid, 0);
        send_beat(4'hA);
        @(posedge clk);
        #1;
        check("gap_ov", out_valid, 1);
        check("gap_Op_final", Op, 5);
        check("gap_A_final", A, 6);
        check("gap_B_final", B, 4'hA);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("gap_count", op_count, 2);

        // Counter wrap with back-to-back operations
        reset_n = 1'b0;
        #1;
        check("wrap_rst_count", op_count, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 4'h0;
        cyc    = 0;
        last   = -1;
        pulses = 0;
        while (pulses < 256 && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid) begin
                if (last >= 0) check("wrap_spacing", cyc - last, 4);
                last = cyc;
                pulses++;
            end
        end
        check("wrap_pulses", pulses, 256);
        check("wrap_count_255", op_count, 255);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("wrap_count_0", op_count, 0);
        check("wrap_ov_drop", out_valid, 0);

        // Opcodes that use only one operand
        send_beat(4'h2);
        send_beat(4'h7);
`ifdef ALU_LOADER_SKIP_EN
        check("skipA_ov", out_valid, 1);
        check("skipA_A", A, 7);
        check("skipA_B", B, 0);
        check("skipA_Op", Op, 2);
`else
        check("noskipA_ov", out_valid, 0);
        check("noskipA_in_ready", in_ready, 1);
        send_beat(4'h4);
        check("noskipA_ov3", out_valid, 1);
        check("noskipA_A", A, 7);
        check("noskipA_B", B, 4);
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("skipA_count", op_count, 1);

        send_beat(4'h3);
        send_beat(4'hC);
`ifdef ALU_LOADER_SKIP_EN
        check("skipB_ov", out_valid, 1);
        check("skipB_A", A, 0);
        check("skipB_B", B, 4'hC);
        check("skipB_Op", Op, 3);
`else
        check("noskipB_ov", out_valid, 0);
        send_beat(4'h8);
        check("noskipB_ov3", out_valid, 1);
        check("noskipB_A", A, 4'hC);
        check("noskipB_B", B, 8);
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("skipB_count", op_count, 2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
